multi_issue_inorder_queue: RTL and testbench

- Parametrised successor to the single-entry-per-cycle in-order instruction queue.
- Sits between decode and dispatch; buffers decoded instruction packets in program order.
- Accepts up to enqWidth packets and releases up to deqWidth packets per cycle.
- Adds flush, occupancy count and almost-full back-pressure.

---
 rtl/ioq_pkg.sv | 59 +++++
 rtl/ioq_ptr_wrap.sv | 16 +
 rtl/multi_issue_inorder_queue.sv | 157 +++++++++++++++
 tb/tb_multi_issue_inorder_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ioq_pkg.sv
// Shared definitions for the multi-issue in-order queue: packet layout,
// functional-unit codes and one-hot instruction format constants.
package ioq_pkg;

  localparam int IOQ_FMT_W   = 25;
  localparam int IOQ_OPC_W   = 12;
  localparam int IOQ_ADDR_W  = 64;
  localparam int IOQ_FU_W    = 3;
  localparam int IOQ_MAJID_W = 64;
  localparam int IOQ_MINID_W = 5;
  localparam int IOQ_IS64_W  = 1;
  localparam int IOQ_PID_W   = 20;
  localparam int IOQ_TID_W   = 16;
  localparam int IOQ_ORW_W   = 8;
  localparam int IOQ_OREG_W  = 4;
  localparam int IOQ_BODY_W  = 84;

  // Fields are packed upward from bit 0 in the order listed above.
  localparam int IOQ_FMT_OFF   = 0;
  localparam int IOQ_OPC_OFF   = IOQ_FMT_OFF   + IOQ_FMT_W;
  localparam int IOQ_ADDR_OFF  = IOQ_OPC_OFF   + IOQ_OPC_W;
  localparam int IOQ_FU_OFF    = IOQ_ADDR_OFF  + IOQ_ADDR_W;
  localparam int IOQ_MAJID_OFF = IOQ_FU_OFF    + IOQ_FU_W;
  localparam int IOQ_MINID_OFF = IOQ_MAJID_OFF + IOQ_MAJID_W;
  localparam int IOQ_IS64_OFF  = IOQ_MINID_OFF + IOQ_MINID_W;
  localparam int IOQ_PID_OFF   = IOQ_IS64_OFF  + IOQ_IS64_W;
  localparam int IOQ_TID_OFF   = IOQ_PID_OFF   + IOQ_PID_W;
  localparam int IOQ_ORW_OFF   = IOQ_TID_OFF   + IOQ_TID_W;
  localparam int IOQ_OREG_OFF  = IOQ_ORW_OFF   + IOQ_ORW_W;
  localparam int IOQ_BODY_OFF  = IOQ_OREG_OFF  + IOQ_OREG_W;
  localparam int IOQ_PAYLOAD_W = IOQ_BODY_OFF  + IOQ_BODY_W;

  typedef enum logic [IOQ_FU_W-1:0] {
    FU_FX     = 3'd0,
    FU_FP     = 3'd1,
    FU_VX     = 3'd2,
    FU_CR     = 3'd3,
    FU_LS     = 3'd4,
    FU_BRANCH = 3'd6
  } func_unit_e;

  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_I   = 25'd1 << 0;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_B   = 25'd1 << 1;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_SC  = 25'd1 << 2;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_D   = 25'd1 << 3;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_DS  = 25'd1 << 4;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_X   = 25'd1 << 5;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_XL  = 25'd1 << 6;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_XFX = 25'd1 << 7;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_XO  = 25'd1 << 8;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_A   = 25'd1 << 9;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_M   = 25'd1 << 10;
  localparam logic [IOQ_FMT_W-1:0] IOQ_FMT_MD  = 25'd1 << 11;

  function automatic logic [IOQ_MAJID_W-1:0] ioq_majid(input logic [IOQ_PAYLOAD_W-1:0] p);
    return p[IOQ_MAJID_OFF +: IOQ_MAJID_W];
  endfunction

endpackage

// File: rtl/ioq_ptr_wrap.sv
// Modulo-depth pointer adder; depth is a power of two so wrapping is a
// plain truncation to IDX_BITS.
module ioq_ptr_wrap
  import ioq_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int ADD_BITS = 2
) (
  input  logic [IDX_BITS-1:0] base,
  input  logic [ADD_BITS-1:0] add,
  output logic [IDX_BITS-1:0] sum
);

  assign sum = base + IDX_BITS'(add);

endmodule

// File: rtl/multi_issue_inorder_queue.sv
// Multi-issue in-order instruction queue between decode and dispatch.
// Optional enqueue performance counters are built when IOQ_PERF_CNT_EN is defined.
module multi_issue_inorder_queue
  import ioq_pkg::*;
#(
  parameter int queueIndexBits      = 3,
  parameter int payloadWidth        = IOQ_PAYLOAD_W,
  parameter int enqWidth            = 2,
  parameter int deqWidth            = 2,
  parameter int almostFullThreshold = 6
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic [enqWidth-1:0]               enqValid_i,
  input  logic [enqWidth*payloadWidth-1:0]  enqPayload_i,
  output logic                              enqReady_o,
  output logic [deqWidth-1:0]               deqValid_o,
  output logic [deqWidth*payloadWidth-1:0]  deqPayload_o,
  input  logic [$clog2(deqWidth+1)-1:0]     deqCount_i,
  output logic [queueIndexBits:0]           count_o,
  output logic [queueIndexBits-1:0]         head_o,
  output logic [queueIndexBits-1:0]         tail_o,
  output logic                              isEmpty_o,
  output logic                              isFull_o,
  output logic                              almostFull_o
`ifdef IOQ_PERF_CNT_EN
  ,
  output logic [31:0]                       enqStallCycles_o,
  output logic [31:0]                       enqTotal_o
`endif
);

  localparam int DEPTH = 1 << queueIndexBits;
  localparam int CW    = queueIndexBits + 1;
  localparam int EW    = $clog2(enqWidth + 1);
  localparam int DW    = $clog2(deqWidth + 1);
  localparam int MW    = (CW > DW) ? CW : DW;

  logic [payloadWidth-1:0]   mem [DEPTH];
  logic [queueIndexBits-1:0] head_q, tail_q;
  logic [CW-1:0]             count_q, count_nxt;
  logic [queueIndexBits-1:0] head_nxt, tail_nxt;
  logic [queueIndexBits-1:0] wr_slot [enqWidth];
  logic [queueIndexBits-1:0] rd_slot [deqWidth];
  logic [enqWidth-1:0]       lane_we;
  logic [EW-1:0]             n_enq;
  logic [DW-1:0]             n_deq;
  logic                      enq_ready;
  logic                      run;

  // Readiness looks only at registered occupancy; a same-cycle pop gives no credit.
  assign enq_ready = (DEPTH - int'(count_q)) >= enqWidth;

  always_comb begin
    run     = 1'b1;
    n_enq   = '0;
    lane_we = '0;
    for (int i = 0; i < enqWidth; i++) begin
      run        = run & enqValid_i[i];
      lane_we[i] = run & enq_ready;
      n_enq      = n_enq + EW'(lane_we[i]);
    end
  end

  always_comb begin
    if (MW'(deqCount_i) > MW'(count_q)) n_deq = DW'(count_q);
    else                                n_deq = deqCount_i;
  end

  assign count_nxt = count_q + CW'(n_enq) - CW'(n_deq);

  ioq_ptr_wrap #(.IDX_BITS(queueIndexBits), .ADD_BITS(EW)) u_tail_wrap (
    .base (tail_q),
    .add  (n_enq),
    .sum  (tail_nxt)
  );

  ioq_ptr_wrap #(.IDX_BITS(queueIndexBits), .ADD_BITS(DW)) u_head_wrap (
    .base (head_q),
    .add  (n_deq),
    .sum  (head_nxt)
  );

  for (genvar i = 0; i < enqWidth; i++) begin : g_wr_slot
    ioq_ptr_wrap #(.IDX_BITS(queueIndexBits), .ADD_BITS(EW)) u_wr_wrap (
      .base (tail_q),
      .add  (EW'(i)),
      .sum  (wr_slot[i])
    );
  end

  for (genvar k = 0; k < deqWidth; k++) begin : g_rd_slot
    ioq_ptr_wrap #(.IDX_BITS(queueIndexBits), .ADD_BITS(DW)) u_rd_wrap (
      .base (head_q),
      .add  (DW'(k)),
      .sum  (rd_slot[k])
    );
    assign deqValid_o[k] = int'(count_q) > k;
    assign deqPayload_o[k*payloadWidth +: payloadWidth] =
      deqValid_o[k] ? mem[rd_slot[k]] : '0;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;
    end
  end

  // Storage is deliberately left unreset; validity comes from count_q alone.
  always_ff @(posedge clock_i) begin
    if (!flush_i) begin
      for (int i = 0; i < enqWidth; i++) begin
        if (lane_we[i]) mem[wr_slot[i]] <= enqPayload_i[i*payloadWidth +: payloadWidth];
      end
    end
  end

  assign enqReady_o   = enq_ready;
  assign count_o      = count_q;
  assign head_o       = head_q;
  assign tail_o       = tail_q;
  assign isEmpty_o    = (count_q == '0);
  assign isFull_o     = (count_q == CW'(DEPTH));
  assign almostFull_o = int'(count_q) >= almostFullThreshold;

`ifdef IOQ_PERF_CNT_EN
  logic [EW-1:0] n_enq_eff;
  logic [32:0]   total_sum;

  assign n_enq_eff = flush_i ? '0 : n_enq;
  assign total_sum = {1'b0, enqTotal_o} + 33'(n_enq_eff);

  // Counters survive flush and saturate instead of wrapping.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      enqStallCycles_o <= '0;
      enqTotal_o       <= '0;
    end else begin
      if (enqValid_i[0] && !enq_ready && (enqStallCycles_o != '1))
        enqStallCycles_o <= enqStallCycles_o + 32'd1;
      enqTotal_o <= total_sum[32] ? '1 : total_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_multi_issue_inorder_queue.sv
// Directed self-checking bench for multi_issue_inorder_queue (default build).
module tb_multi_issue_inorder_queue;
  import ioq_pkg::*;

  localparam int PW = IOQ_PAYLOAD_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    enq_valid = 2'b00;
  logic [2*PW-1:0] enq_payload = '0;
  logic          enq_ready;
  logic [1:0]    deq_valid;
  logic [2*PW-1:0] deq_payload;
  logic [1:0]    deq_count = 2'd0;
  logic [3:0]    count;
  logic [2:0]    head, tail;
  logic          is_empty, is_full, almost_full;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_issue_inorder_queue dut (
    .clock_i      (clk),
    .reset_i      (rst_n),
    .flush_i      (flush),
    .enqValid_i   (enq_valid),
    .enqPayload_i (enq_payload),
    .enqReady_o   (enq_ready),
    .deqValid_o   (deq_valid),
    .deqPayload_o (deq_payload),
    .deqCount_i   (deq_count),
    .count_o      (count),
    .head_o       (head),
    .tail_o       (tail),
    .isEmpty_o    (is_empty),
    .isFull_o     (is_full),
    .almostFull_o (almost_full)
  );

  function automatic logic [PW-1:0] mk(input logic [63:0] id);
    logic [PW-1:0] p;
    p = '0;
    p[IOQ_FMT_OFF +: IOQ_FMT_W]     = IOQ_FMT_X;
    p[IOQ_FU_OFF +: IOQ_FU_W]       = FU_LS;
    p[IOQ_MAJID_OFF +: IOQ_MAJID_W] = id;
    p[IOQ_PID_OFF +: IOQ_PID_W]     = id[19:0] ^ 20'h5A5A5;
    p[IOQ_BODY_OFF +: IOQ_BODY_W]   = {id[19:0], ~id};
    return p;
  endfunction

  function automatic logic [63:0] maj(input int k);
    return deq_payload[k*PW + IOQ_MAJID_OFF +: 64];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (head !== 3'd0 || tail !== 3'd0) begin n_fail++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", head, tail); end
    n_checks++; if (is_empty !== 1'b1 || is_full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_status got e%b f%b af%b want e1 f0 af0", is_empty, is_full, almost_full); end
    n_checks++; if (deq_valid !== 2'b00 || deq_payload !== '0) begin n_fail++; $display("FAIL reset_deq got valid %b want 00 and zero payload", deq_valid); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", enq_ready); end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_single();
    enq_valid = 2'b01; enq_payload = {mk(64'd99), mk(64'd0)};
    step();
    enq_valid = 2'b00;
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    n_checks++; if (deq_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid got %b want 01", deq_valid); end
    n_checks++; if (deq_payload[PW-1:0] !== mk(64'd0)) begin n_fail++; $display("FAIL single_payload lane0 majid got %0d want 0", maj(0)); end
    n_checks++; if (deq_payload[2*PW-1:PW] !== '0) begin n_fail++; $display("FAIL single_lane1_zero got majid %0d want 0 payload", maj(1)); end
    n_checks++; if (is_empty !== 1'b0 || tail !== 3'd1) begin n_fail++; $display("FAIL single_state got e%b tail %0d want e0 tail 1", is_empty, tail); end
    deq_count = 2'd1;
    step();
    deq_count = 2'd0;
    n_checks++; if (is_empty !== 1'b1 || head !== 3'd1) begin n_fail++; $display("FAIL single_pop got e%b head %0d want e1 head 1", is_empty, head); end
  endtask

  task automatic test_two_lane();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (head !== 3'd0 || tail !== 3'd0 || count !== 4'd0) begin n_fail++; $display("FAIL two_flush got h%0d t%0d c%0d want 0/0/0", head, tail, count); end
    enq_valid = 2'b11; enq_payload = {mk(64'd2), mk(64'd1)};
    step();
    enq_valid = 2'b00;
    n_checks++; if (count !== 4'd2 || deq_valid !== 2'b11) begin n_fail++; $display("FAIL two_count got c%0d v%b want c2 v11", count, deq_valid); end
    n_checks++; if (maj(0) !== 64'd1 || maj(1) !== 64'd2) begin n_fail++; $display("FAIL two_order got %0d,%0d want 1,2", maj(0), maj(1)); end
    deq_count = 2'd2;
    step();
    deq_count = 2'd0;
    n_checks++; if (is_empty !== 1'b1 || head !== 3'd2 || tail !== 3'd2) begin n_fail++; $display("FAIL two_pop got e%b h%0d t%0d want e1 h2 t2", is_empty, head, tail); end
  endtask

  task automatic test_lane_gap();
    enq_valid = 2'b10; enq_payload = {mk(64'd50), mk(64'd51)};
    step();
    enq_valid = 2'b00;
    n_checks++; if (count !== 4'd0 || tail !== 3'd2) begin n_fail++; $display("FAIL gap_ignored got c%0d t%0d want c0 t2", count, tail); end
  endtask

  task automatic test_fill();
    logic exp_af, exp_full, exp_rdy;
    for (int w = 0; w < 4; w++) begin
      enq_valid = 2'b11; enq_payload = {mk(64'(2*w+1)), mk(64'(2*w))};
      step();
      exp_af = (w >= 2); exp_full = (w == 3); exp_rdy = (w < 3);
      n_checks++; if (count !== 4'(2*(w+1))) begin n_fail++; $display("FAIL fill_count w%0d got %0d want %0d", w, count, 2*(w+1)); end
      n_checks++; if (almost_full !== exp_af || is_full !== exp_full || enq_ready !== exp_rdy) begin n_fail++; $display("FAIL fill_status w%0d got af%b f%b r%b want af%b f%b r%b", w, almost_full, is_full, enq_ready, exp_af, exp_full, exp_rdy); end
    end
    enq_payload = {mk(64'd9), mk(64'd8)};
    step();
    enq_valid = 2'b00;
    n_checks++; if (count !== 4'd8 || tail !== 3'd2) begin n_fail++; $display("FAIL fill_overflow got c%0d t%0d want c8 t2", count, tail); end
    n_checks++; if (maj(0) !== 64'd0 || maj(1) !== 64'd1) begin n_fail++; $display("FAIL fill_head got %0d,%0d want 0,1", maj(0), maj(1)); end
  endtask

  task automatic test_full_deq();
    enq_valid = 2'b11; enq_payload = {mk(64'd11), mk(64'd10)}; deq_count = 2'd1;
    step();
    enq_valid = 2'b00; deq_count = 2'd0;
    n_checks++; if (count !== 4'd7 || head !== 3'd3 || tail !== 3'd2) begin n_fail++; $display("FAIL fulldeq_state got c%0d h%0d t%0d want c7 h3 t2", count, head, tail); end
    n_checks++; if (enq_ready !== 1'b0 || is_full !== 1'b0 || almost_full !== 1'b1) begin n_fail++; $display("FAIL fulldeq_status got r%b f%b af%b want r0 f0 af1", enq_ready, is_full, almost_full); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (maj(0) !== 64'(1+2*k) || maj(1) !== 64'(2+2*k)) begin n_fail++; $display("FAIL drain_order k%0d got %0d,%0d want %0d,%0d", k, maj(0), maj(1), 1+2*k, 2+2*k); end
      deq_count = 2'd2;
      step();
    end
    n_checks++; if (count !== 4'd1 || deq_valid !== 2'b01 || maj(0) !== 64'd7) begin n_fail++; $display("FAIL drain_last got c%0d v%b id%0d want c1 v01 id7", count, deq_valid, maj(0)); end
    step();
    deq_count = 2'd0;
    n_checks++; if (count !== 4'd0 || head !== 3'd2 || is_empty !== 1'b1) begin n_fail++; $display("FAIL drain_clamp got c%0d h%0d e%b want c0 h2 e1", count, head, is_empty); end
  endtask

  task automatic test_wrap();
    flush = 1'b1;
    step();
    flush = 1'b0;
    enq_valid = 2'b01; deq_count = 2'd1;
    for (int i = 0; i < 7; i++) begin
      enq_payload = {mk(64'd0), mk(64'(20+i))};
      step();
    end
    enq_valid = 2'b00;
    step();
    deq_count = 2'd0;
    n_checks++; if (head !== 3'd7 || tail !== 3'd7 || is_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_setup got h%0d t%0d e%b want h7 t7 e1", head, tail, is_empty); end
    enq_valid = 2'b11; enq_payload = {mk(64'hB), mk(64'hA)};
    step();
    enq_valid = 2'b00;
    n_checks++; if (tail !== 3'd1 || head !== 3'd7 || count !== 4'd2) begin n_fail++; $display("FAIL wrap_ptrs got h%0d t%0d c%0d want h7 t1 c2", head, tail, count); end
    n_checks++; if (maj(0) !== 64'hA || deq_payload[2*PW-1:PW] !== mk(64'hB)) begin n_fail++; $display("FAIL wrap_data got %0h,%0h want a,b", maj(0), maj(1)); end
    deq_count = 2'd1;
    step();
    n_checks++; if (maj(0) !== 64'hB || head !== 3'd0 || count !== 4'd1) begin n_fail++; $display("FAIL wrap_pop got id%0h h%0d c%0d want idb h0 c1", maj(0), head, count); end
    step();
    deq_count = 2'd0;
    n_checks++; if (is_empty !== 1'b1 || head !== 3'd1) begin n_fail++; $display("FAIL wrap_empty got e%b h%0d want e1 h1", is_empty, head); end
  endtask

  task automatic test_flush();
    enq_valid = 2'b11; enq_payload = {mk(64'd31), mk(64'd30)};
    step();
    enq_payload = {mk(64'd33), mk(64'd32)};
    step();
    enq_valid = 2'b01; enq_payload = {mk(64'd0), mk(64'd34)};
    step();
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_setup got %0d want 5", count); end
    flush = 1'b1; enq_valid = 2'b11; enq_payload = {mk(64'd36), mk(64'd35)}; deq_count = 2'd2;
    step();
    flush = 1'b0; enq_valid = 2'b00; deq_count = 2'd0;
    n_checks++; if (count !== 4'd0 || head !== 3'd0 || tail !== 3'd0) begin n_fail++; $display("FAIL flush_state got c%0d h%0d t%0d want 0/0/0", count, head, tail); end
    n_checks++; if (is_empty !== 1'b1 || deq_valid !== 2'b00 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_status got e%b v%b r%b want e1 v00 r1", is_empty, deq_valid, enq_ready); end
  endtask

  task automatic test_async_reset();
    enq_valid = 2'b11; enq_payload = {mk(64'd41), mk(64'd40)};
    step();
    step();
    deq_count = 2'd1;
    step();
    n_checks++; if (count !== 4'd5 || head !== 3'd1 || tail !== 3'd6) begin n_fail++; $display("FAIL areset_setup got c%0d h%0d t%0d want c5 h1 t6", count, head, tail); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || head !== 3'd0 || tail !== 3'd0) begin n_fail++; $display("FAIL areset_ptrs got c%0d h%0d t%0d want 0/0/0", count, head, tail); end
    n_checks++; if (deq_valid !== 2'b00 || deq_payload !== '0 || is_empty !== 1'b1 || enq_ready !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL areset_outputs got v%b e%b r%b af%b want v00 e1 r1 af0", deq_valid, is_empty, enq_ready, almost_full); end
    enq_valid = 2'b00; deq_count = 2'd0;
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (count !== 4'd0 || is_empty !== 1'b1) begin n_fail++; $display("FAIL areset_release got c%0d e%b want c0 e1", count, is_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_lane();
    test_lane_gap();
    test_fill();
    test_full_deq();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
